// File: rtl/sargantana_icache_refill_buffer.sv
// sargantana_icache_refill_buffer
// Line-fill buffer in front of the icache way SRAMs. It gathers NUM_BEATS
// response beats from L2/memory into one cache line, then issues a single
// full-line write to the victim way. The write is held until the arbiter
// grants the port. flush_i aborts the refill at any point. Only one refill
// is in flight at a time.
//
// Ports
//   clk_i, rstn_i        clock, async active-low reset
//   refill_start_i       one-cycle start; samples refill_idx_i / refill_way_i
//   refill_busy_o        high while filling or writing
//   beat_valid_i/data_i  response beats; accepted when beat_ready_o is high
//   flush_i              abort; also masks the SRAM request in the same cycle
//   way_req_o/we_o       per-way SRAM request and write enable
//   way_addr_o/data_o    latched set index and assembled line
//   way_gnt_i            arbiter grant; the write happens on req && gnt
//   done_o               one-cycle pulse in the cycle after the line is written
module sargantana_icache_refill_buffer #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 6,
  parameter int BEAT_WIDTH = 64,
  parameter int WAYS       = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  refill_start_i,
  input  logic [ADDR_WIDHT-1:0] refill_idx_i,
  input  logic [WAYS-1:0]       refill_way_i,
  output logic                  refill_busy_o,
  input  logic                  beat_valid_i,
  input  logic [BEAT_WIDTH-1:0] beat_data_i,
  output logic                  beat_ready_o,
  input  logic                  flush_i,
  output logic [WAYS-1:0]       way_req_o,
  output logic                  way_we_o,
  output logic [ADDR_WIDHT-1:0] way_addr_o,
  output logic [SET_WIDHT-1:0]  way_data_o,
  input  logic                  way_gnt_i,
  output logic                  done_o
);

  localparam int NUM_BEATS = SET_WIDHT / BEAT_WIDTH;
  // Keep the counter at least one bit wide so NUM_BEATS == 1 still elaborates.
  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                               state;
  logic [CNT_W-1:0]                     cnt;
  logic [ADDR_WIDHT-1:0]                idx_q;
  logic [WAYS-1:0]                      way_q;
  logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] line_q;

  // A beat is only stored in FILL, and never in a cycle that is aborted.
  logic beat_take;
  assign beat_take = (state == FILL) && beat_valid_i && !flush_i;

  // flush_i is masked in combinationally so that a flush arriving together
  // with the grant still suppresses the write.
  assign way_req_o     = (state == WRITE) ? (way_q & {WAYS{!flush_i}}) : '0;
  assign way_we_o      = |way_req_o;
  assign way_addr_o    = idx_q;
  assign way_data_o    = line_q;
  assign refill_busy_o = (state != IDLE);
  assign beat_ready_o  = (state == FILL);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      way_q  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (refill_start_i) begin
              idx_q <= refill_idx_i;
              way_q <= refill_way_i;
              cnt   <= '0;
              state <= FILL;
            end
          end
          FILL: begin
            if (beat_valid_i) begin
              if (cnt == LAST_BEAT) begin
                cnt   <= '0;
                state <= WRITE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          WRITE: begin
            if (way_we_o && way_gnt_i) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // One storage slot per beat; beat 0 lands in the line's LSBs.
  for (genvar b = 0; b < NUM_BEATS; b++) begin : g_slot
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
        line_q[b] <= '0;
      else if (beat_take && (cnt == CNT_W'(b)))
        line_q[b] <= beat_data_i;
    end
  end

endmodule
